// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;
  localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
  localparam int unsigned BRU_XLEN      = 32;

  typedef struct packed {
    logic [BRU_XLEN-1:0] pc;
    logic                pred;
    logic [BRU_XLEN-1:0] target;
  } bru_entry_t;
endpackage

// File: rtl/bru_fifo.sv
// In-order circular queue with push/pop/clear; clear wins and discards a concurrent push.
module bru_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop_i & ~empty;
    // a pop in the same cycle frees the slot, so a full queue still accepts
    do_push = push_i & (~full | do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear_i && do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted branches against MEM outcomes; registered redirect and predictor training.
// Optional saturating statistics counters enabled by defining BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned IDX_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_pc,
  input  logic                  push_pred,
  input  logic [DATA_WIDTH-1:0] push_target,
  output logic                  push_ready,
  input  logic                  res_valid,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  upd_valid,
  output logic [IDX_W-1:0]      upd_index,
  output logic                  upd_taken,
  output logic [1:0]            err,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispred
);
  localparam int unsigned EW = 2*DATA_WIDTH + 1;
  localparam int unsigned CW = $clog2(QDEPTH+1);

  logic [EW-1:0]         head;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head_pc, head_tgt;
  logic                  head_pred, pop_en, mispredict, clear, full;

  logic                  redirect_q, upd_valid_q, upd_taken_q;
  logic [DATA_WIDTH-1:0] redirect_pc_q;
  logic [IDX_W-1:0]      upd_index_q;
  logic [1:0]            err_q;

  bru_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_valid),
    .pop_i   (res_valid),
    .clear_i (clear),
    .din_i   ({push_pc, push_pred, push_target}),
    .dout_o  (head),
    .count_o (count)
  );

  always_comb begin
    head_pc    = head[EW-1 -: DATA_WIDTH];
    head_pred  = head[DATA_WIDTH];
    head_tgt   = head[DATA_WIDTH-1:0];
    full       = (count == CW'(QDEPTH));
    pop_en     = res_valid & (count != '0);
    mispredict = (head_pred != res_taken) | (head_pred & res_taken & (head_tgt != res_target));
    // younger entries are wrong-path after a mispredict
    clear      = pop_en & mispredict;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      err_q         <= '0;
    end else begin
      redirect_q  <= pop_en & mispredict;
      upd_valid_q <= pop_en;
      if (pop_en) begin
        redirect_pc_q <= res_taken ? res_target : head_pc + DATA_WIDTH'(4);
        upd_index_q   <= head_pc[IDX_W+1:2];
        upd_taken_q   <= res_taken;
      end
      if (res_valid && count == '0)      err_q[0] <= 1'b1;
      if (push_valid && full && !pop_en) err_q[1] <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (pop_en && stat_br_q != '1)              stat_br_q <= stat_br_q + 32'd1;
      if (pop_en && mispredict && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

  assign push_ready  = (count != CW'(QDEPTH));
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign err         = err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors, monitor compares every update pulse.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0, push_pred = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] push_pc = '0, push_target = '0, res_target = '0;
  logic        push_ready, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, stat_branches, stat_mispred;
  logic [9:0]  upd_index;
  logic [1:0]  err;

  typedef struct {
    logic        redirect;
    logic [31:0] pc;
    logic [9:0]  idx;
    logic        taken;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_WIDTH(32), .QDEPTH(4), .IDX_W(10)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred), .push_target(push_target),
    .push_ready(push_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .err(err), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic cyc(input bit pv, input logic [31:0] ppc, input bit pp, input logic [31:0] pt,
                     input bit rv, input bit rt, input logic [31:0] rtg);
    @(negedge clk);
    push_valid = pv; push_pc = ppc; push_pred = pp; push_target = pt;
    res_valid = rv; res_taken = rt; res_target = rtg;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_upd(input bit r, input logic [31:0] pc, input logic [9:0] idx, input bit t);
    exp_t e;
    e.redirect = r; e.pc = pc; e.idx = idx; e.taken = t;
    sb.push_back(e);
  endtask

  // Monitor: every update pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (redirect && !upd_valid) chk("redirect_without_upd", 64'(redirect), 64'(0));
      if (upd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_upd", 64'(upd_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("redirect", 64'(redirect), 64'(e.redirect));
          chk("redirect_pc", 64'(redirect_pc), 64'(e.pc));
          chk("upd_index", 64'(upd_index), 64'(e.idx));
          chk("upd_taken", 64'(upd_taken), 64'(e.taken));
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_redirect", 64'(redirect), 0);
    chk("rst_redirect_pc", 64'(redirect_pc), 0);
    chk("rst_upd_valid", 64'(upd_valid), 0);
    chk("rst_upd_index", 64'(upd_index), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_push_ready", 64'(push_ready), 1);
    rst = 1'b0;

    // 1: correct not-taken prediction
    cyc(1, 32'h100, 0, 32'h140, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h140);
    expect_upd(0, 32'h104, 10'h040, 0);

    // 2: predicted not-taken, actually taken
    cyc(1, 32'h100, 0, 32'h140, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h140);
    expect_upd(1, 32'h140, 10'h040, 1);

    // 3: predicted taken, not taken; younger entry and same-cycle push are flushed
    cyc(1, 32'h200, 1, 32'h180, 0, 0, 0);
    cyc(1, 32'h204, 0, 32'h300, 0, 0, 0);
    cyc(1, 32'h300, 0, 32'h340, 1, 0, 32'h180);
    expect_upd(1, 32'h204, 10'h080, 0);
    idle();
    chk("err_before_empty_pop", 64'(err), 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h999);
    idle();
    chk("err_pop_empty", 64'(err), 64'(2'b01));

    // 4: taken as predicted but target differs
    cyc(1, 32'h2F0, 1, 32'h300, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h304);
    expect_upd(1, 32'h304, 10'h0BC, 1);

    // 5: fill, overflow, pop+push while full, FIFO order
    cyc(1, 32'h10, 0, 32'h80, 0, 0, 0);
    cyc(1, 32'h14, 0, 32'h80, 0, 0, 0);
    cyc(1, 32'h18, 0, 32'h80, 0, 0, 0);
    cyc(1, 32'h1C, 0, 32'h80, 0, 0, 0);
    idle();
    chk("full_push_ready", 64'(push_ready), 0);
    cyc(1, 32'h20, 0, 32'h80, 0, 0, 0);
    idle();
    chk("err_push_full", 64'(err), 64'(2'b11));
    cyc(1, 32'h24, 0, 32'h80, 1, 0, 32'h80);
    expect_upd(0, 32'h14, 10'h004, 0);
    idle();
    chk("still_full", 64'(push_ready), 0);
    cyc(0, 0, 0, 0, 1, 0, 0); expect_upd(0, 32'h18, 10'h005, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); expect_upd(0, 32'h1C, 10'h006, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); expect_upd(0, 32'h20, 10'h007, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); expect_upd(0, 32'h28, 10'h009, 0);
    idle();
    chk("drained_push_ready", 64'(push_ready), 1);

    // 6: reset mid-stream right after a mispredict resolves
    cyc(1, 32'h500, 0, 32'h520, 0, 0, 0);
    cyc(1, 32'h504, 0, 32'h520, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h520);
    expect_upd(1, 32'h520, 10'h140, 1);
    cyc(1, 32'h600, 0, 0, 1, 0, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst2_redirect", 64'(redirect), 0);
    chk("rst2_redirect_pc", 64'(redirect_pc), 0);
    chk("rst2_upd_valid", 64'(upd_valid), 0);
    chk("rst2_upd_index", 64'(upd_index), 0);
    chk("rst2_upd_taken", 64'(upd_taken), 0);
    chk("rst2_err", 64'(err), 0);
    chk("rst2_push_ready", 64'(push_ready), 1);
    chk("rst2_stat_br", 64'(stat_branches), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("rst2_queue_empty", 64'(err), 64'(2'b01));

    // three pops, one mispredict
    cyc(1, 32'h600, 0, 32'h640, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);          expect_upd(0, 32'h604, 10'h180, 0);
    cyc(1, 32'h604, 1, 32'h700, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h700);    expect_upd(0, 32'h700, 10'h181, 1);
    cyc(1, 32'h608, 0, 32'h640, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h640);    expect_upd(1, 32'h640, 10'h182, 1);
    idle();
    idle();
`ifdef BRU_STATS_EN
    chk("stat_branches", 64'(stat_branches), 3);
    chk("stat_mispred", 64'(stat_mispred), 1);
`else
    chk("stat_branches_tied", 64'(stat_branches), 0);
    chk("stat_mispred_tied", 64'(stat_mispred), 0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
